// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Shares the CPU's single external memory port between the instruction fetch
// requester and the data load/store requester. One transaction is granted at
// a time. When both requesters ask in the same cycle, the grant alternates
// (round-robin). A grant is held until the memory completes the transaction
// or the watchdog gives up on it. Completion, error and read data go back to
// the granted requester only.
//
// Ports:
//   clock, reset               rising-edge clock, asynchronous active-high reset
//   instruction_request        fetch request, held until ready/error
//   instruction_address        fetch address
//   instruction_ready/_error   one-cycle completion / watchdog-abort pulses
//   instruction_data           fetched word, valid with instruction_ready
//   data_request               load/store request, held until ready/error
//   data_write                 1 = store, 0 = load
//   data_address               load/store address
//   data_write_data            store data
//   data_byte_enable           store byte lanes
//   data_ready/_error          one-cycle completion / watchdog-abort pulses
//   data_read_data             load result, valid with data_ready
//   memory_request             transaction active on the memory port
//   memory_write               store when high
//   memory_address             latched address
//   memory_write_data          latched store data
//   memory_byte_enable         latched lanes, all ones for fetches and loads
//   memory_ready               memory completes the transaction this cycle
//   memory_read_data           read data, valid with memory_ready
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      instruction_request,
    input  logic [ADDRESS_WIDTH-1:0]  instruction_address,
    output logic                      instruction_ready,
    output logic                      instruction_error,
    output logic [DATA_WIDTH-1:0]     instruction_data,

    input  logic                      data_request,
    input  logic                      data_write,
    input  logic [ADDRESS_WIDTH-1:0]  data_address,
    input  logic [DATA_WIDTH-1:0]     data_write_data,
    input  logic [DATA_WIDTH/8-1:0]   data_byte_enable,
    output logic                      data_ready,
    output logic                      data_error,
    output logic [DATA_WIDTH-1:0]     data_read_data,

    output logic                      memory_request,
    output logic                      memory_write,
    output logic [ADDRESS_WIDTH-1:0]  memory_address,
    output logic [DATA_WIDTH-1:0]     memory_write_data,
    output logic [DATA_WIDTH/8-1:0]   memory_byte_enable,
    input  logic                      memory_ready,
    input  logic [DATA_WIDTH-1:0]     memory_read_data
);

    localparam int BYTE_WIDTH  = DATA_WIDTH / 8;
    localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES > 0);
    // The counter only ever has to reach TIMEOUT_CYCLES, never wrap past it.
    localparam int COUNT_WIDTH = WATCHDOG_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE     = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_INSTRUCTION,
        BUSY_DATA
    } state_t;

    typedef enum logic {
        GRANT_INSTRUCTION,
        GRANT_DATA
    } grant_t;

    state_t                  state;
    grant_t                  last_grant;
    logic [COUNT_WIDTH-1:0]  watchdog_count;

    logic busy;
    logic timed_out;
    logic grant_data;
    logic grant_instruction;

    // Arbitration and watchdog decisions. Data wins a tie whenever the
    // previous grant went to instruction fetch, and vice versa. A timeout is
    // only declared when memory_ready is absent, so a completion arriving on
    // the final allowed cycle is still honoured.
    always_comb begin
        busy              = (state != IDLE);
        timed_out         = WATCHDOG_ON && busy && !memory_ready &&
                            (watchdog_count == TIMEOUT_LIMIT);
        grant_data        = data_request &&
                            (!instruction_request || (last_grant == GRANT_INSTRUCTION));
        grant_instruction = instruction_request && !grant_data;
    end

    // Completion and abort pulses are steered to the owner of the current
    // grant. Read data is passed straight through to both requesters; only
    // the one seeing a ready pulse treats it as valid.
    always_comb begin
        instruction_ready = (state == BUSY_INSTRUCTION) && memory_ready;
        instruction_error = (state == BUSY_INSTRUCTION) && timed_out;
        data_ready        = (state == BUSY_DATA) && memory_ready;
        data_error        = (state == BUSY_DATA) && timed_out;
        instruction_data  = memory_read_data;
        data_read_data    = memory_read_data;
    end

    // Arbiter state machine. The request fields are captured once at grant
    // time into the memory_* registers and held there for the whole
    // transaction, so requesters need not keep them stable for the memory.
    // Leaving a busy state always passes through IDLE for one cycle, which
    // gives the finished requester time to drop its request before the next
    // arbitration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            last_grant         <= GRANT_INSTRUCTION;
            watchdog_count     <= '0;
            memory_request     <= 1'b0;
            memory_write       <= 1'b0;
            memory_address     <= '0;
            memory_write_data  <= '0;
            memory_byte_enable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    watchdog_count <= '0;
                    if (grant_data) begin
                        memory_request     <= 1'b1;
                        memory_write       <= data_write;
                        memory_address     <= data_address;
                        memory_write_data  <= data_write_data;
                        // Loads read whole words; lane selection is a store concern.
                        memory_byte_enable <= data_write ? data_byte_enable : {BYTE_WIDTH{1'b1}};
                        last_grant         <= GRANT_DATA;
                        state              <= BUSY_DATA;
                    end else if (grant_instruction) begin
                        memory_request     <= 1'b1;
                        memory_write       <= 1'b0;
                        memory_address     <= instruction_address;
                        memory_write_data  <= '0;
                        memory_byte_enable <= {BYTE_WIDTH{1'b1}};
                        last_grant         <= GRANT_INSTRUCTION;
                        state              <= BUSY_INSTRUCTION;
                    end
                end

                BUSY_INSTRUCTION,
                BUSY_DATA: begin
                    if (memory_ready || timed_out) begin
                        memory_request <= 1'b0;
                        watchdog_count <= '0;
                        state          <= IDLE;
                    end else if (WATCHDOG_ON) begin
                        watchdog_count <= watchdog_count + COUNT_ONE;
                    end
                end

                default: begin
                    memory_request <= 1'b0;
                    watchdog_count <= '0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
